// File: rtl/updown_load_counter.sv
// updown_load_counter
//   WIDTH-bit binary up/down counter with synchronous clear, parallel load
//   and count enable. ovf is a one-cycle wrap pulse. It is registered together
//   with count, so it is high in the same cycle that the wrapped value appears.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (count=0, ovf=0)
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load of load_val (beats en)
//   en        count enable
//   down      direction: 0 = up, 1 = down
//   load_val  16-bit load value, zero-extended or truncated to WIDTH
//   count     registered count
//   ovf       registered wrap pulse
module updown_load_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [15:0]      load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] load_mapped;

  // Fit the fixed 16-bit load port to the counter width.
  if (WIDTH > 16) begin : g_load_ext
    assign load_mapped = {{(WIDTH-16){1'b0}}, load_val};
  end else if (WIDTH == 16) begin : g_load_same
    assign load_mapped = load_val;
  end else begin : g_load_trunc
    assign load_mapped = load_val[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_mapped;
      ovf   <= 1'b0;
    end else if (en) begin
      if (down) begin
        count <= count - ONE;
        ovf   <= (count == '0);
      end else begin
        count <= count + ONE;
        ovf   <= &count;
      end
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_load_counter.sv
module tb_updown_load_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, en, down, load;
  logic [15:0] load_val;
  logic [3:0]  count4;
  logic        ovf4;
  logic [19:0] count20;
  logic        ovf20;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: plain integers, updated with modular arithmetic.
  longint m4, m20;
  bit     mo4, mo20;

  always #5 clk = ~clk;

  updown_load_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .down(down), .load(load),
    .load_val(load_val), .count(count4), .ovf(ovf4)
  );

  updown_load_counter #(.WIDTH(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .down(down), .load(load),
    .load_val(load_val), .count(count20), .ovf(ovf20)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One counter step of width w, derived from the behavioural rules.
  task automatic model_step(input int w, inout longint c, output bit o);
    longint modv;
    modv = longint'(1) << w;
    o = 1'b0;
    if (clr) c = 0;
    else if (load) c = longint'(load_val) % modv;
    else if (en) begin
      if (down) begin
        o = (c == 0);
        c = (c + modv - 1) % modv;
      end else begin
        o = (c == modv - 1);
        c = (c + 1) % modv;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(4, m4, mo4);
    model_step(20, m20, mo20);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " count4"},  count4,  m4);
    chk({tag, " ovf4"},    ovf4,    mo4);
    chk({tag, " count20"}, count20, m20);
    chk({tag, " ovf20"},   ovf20,   mo20);
  endtask

  task automatic set_in(input bit c, input bit e, input bit d, input bit l,
                        input logic [15:0] v);
    clr = c; en = e; down = d; load = l; load_val = v;
  endtask

  typedef struct {
    bit          clr, en, down, load;
    logic [15:0] lv;
    logic [3:0]  ec;
    bit          eo;
  } vec_t;

  vec_t vec[18];

  initial begin
    // clr, en, down, load, load_val, expected count4, expected ovf4
    vec[0]  = '{1, 1, 0, 0, 16'h0000, 4'h0, 0};
    vec[1]  = '{0, 1, 1, 0, 16'h0000, 4'hF, 1};
    vec[2]  = '{0, 1, 1, 0, 16'h0000, 4'hE, 0};
    vec[3]  = '{0, 1, 0, 1, 16'h00A9, 4'h9, 0};
    vec[4]  = '{0, 0, 0, 1, 16'h0005, 4'h5, 0};
    vec[5]  = '{1, 1, 0, 1, 16'h0007, 4'h0, 0};
    vec[6]  = '{0, 1, 0, 1, 16'h0007, 4'h7, 0};
    vec[7]  = '{0, 0, 0, 1, 16'h0003, 4'h3, 0};
    vec[8]  = '{0, 0, 0, 0, 16'h0000, 4'h3, 0};
    vec[9]  = '{0, 0, 1, 0, 16'h0000, 4'h3, 0};
    vec[10] = '{0, 0, 0, 0, 16'h0000, 4'h3, 0};
    vec[11] = '{0, 0, 1, 0, 16'h0000, 4'h3, 0};
    vec[12] = '{0, 0, 0, 0, 16'h0000, 4'h3, 0};
    vec[13] = '{0, 1, 0, 1, 16'hBEEF, 4'hF, 0};
    vec[14] = '{0, 1, 0, 0, 16'h0000, 4'h0, 1};
    vec[15] = '{0, 0, 0, 0, 16'h0000, 4'h0, 0};
    vec[16] = '{0, 1, 1, 0, 16'h0000, 4'hF, 1};
    vec[17] = '{0, 1, 0, 0, 16'h0000, 4'h0, 1};

    set_in(0, 0, 0, 0, 16'h0000);
    rst_n = 1'b0;
    m4 = 0; m20 = 0; mo4 = 0; mo20 = 0;
    #2;
    chk("reset count4", count4, 0);
    chk("reset ovf4", ovf4, 0);
    chk("reset count20", count20, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Free-running up count across the 4-bit wrap.
    set_in(0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 17; i++) begin
      step();
      chk($sformatf("up%0d count4", i), count4, (i + 1) % 16);
      chk($sformatf("up%0d ovf4", i), ovf4, (i == 15));
      chk($sformatf("up%0d count20", i), count20, m20);
    end

    for (int i = 0; i < 18; i++) begin
      set_in(vec[i].clr, vec[i].en, vec[i].down, vec[i].load, vec[i].lv);
      step();
      chk($sformatf("vec%0d count4", i), count4, vec[i].ec);
      chk($sformatf("vec%0d ovf4", i), ovf4, vec[i].eo);
      chk($sformatf("vec%0d count20", i), count20, m20);
      chk($sformatf("vec%0d ovf20", i), ovf20, mo20);
      if (i == 13) chk("load BEEF count20", count20, 20'h0BEEF);
    end

    // Asynchronous reset between edges.
    set_in(0, 1, 0, 1, 16'h000C);
    step();
    chk("pre-reset count4", count4, 12);
    set_in(0, 1, 0, 0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset count4", count4, 0);
    chk("async reset ovf4", ovf4, 0);
    chk("async reset count20", count20, 0);
    m4 = 0; m20 = 0; mo4 = 0; mo20 = 0;
    #1 rst_n = 1'b1;
    step();
    chk("post-reset count4", count4, 1);
    chk("post-reset count20", count20, 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
             $urandom_range(7) == 0, 16'($urandom));
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

endmodule
